digit_entry_writer: RTL and testbench

- Producer side of the 40-bit digit memory that the rolling seven-segment display reads.
- Lets a user compose a 10-digit word with three pushbuttons (increment, next-digit, commit).
- Button inputs are synchronised and debounced inside the block.
- On commit, the working buffer is published on mem, and mem_valid pulses for one cycle.
- Also exports cursor position and a blink strobe so the top level can highlight the digit being edited.

---
 rtl/digit_entry_writer.sv | 147 ++++++++++++++
 tb/tb_digit_entry_writer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_entry_writer.sv
// Pushbutton-driven editor for a 10-digit (40-bit) word: debounced keys step a digit,
// move the cursor and publish the working buffer to the display memory.
module digit_entry_writer #(
   parameter int          DEBOUNCE_CNT = 1_000_000,
   parameter int          BLINK_CNT    = 12_500_000,
   parameter int          DIGIT_MAX    = 15,
   parameter logic [39:0] INIT_MEM     = 40'h0987654321
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_inc_n,
   input  logic        key_next_n,
   input  logic        key_commit_n,
   output logic [39:0] mem,
   output logic        mem_valid,
   output logic [3:0]  cursor,
   output logic [3:0]  edit_digit,
   output logic        blink,
   output logic        dirty
);

   localparam int L_CNT_MAX = (DEBOUNCE_CNT > BLINK_CNT) ? DEBOUNCE_CNT : BLINK_CNT;
   localparam int CW        = ($clog2(L_CNT_MAX) < 1) ? 1 : $clog2(L_CNT_MAX);
   localparam logic [CW-1:0] L_DEB_LAST   = CW'(DEBOUNCE_CNT - 1);
   localparam logic [CW-1:0] L_BLINK_LAST = CW'(BLINK_CNT - 1);
   localparam logic [3:0]    L_DIGIT_MAX  = 4'(DIGIT_MAX);

   typedef enum logic {S_EDIT, S_COMMIT} state_t;

   state_t        r_state, w_state_next;
   logic [39:0]   r_buf, w_buf_next;
   logic [39:0]   r_mem, w_mem_next;
   logic [3:0]    r_cursor, w_cursor_next;
   logic          r_mem_valid, w_mem_valid_next;
   logic [CW-1:0] r_blink_cnt;
   logic          r_blink;
   logic [3:0]    w_edit_digit;

   // Key index 0 = inc, 1 = next, 2 = commit
   logic [2:0]    w_key_raw;
   logic [2:0]    w_press;
   logic          r_sync1  [3];
   logic          r_sync2  [3];
   logic          r_stable [3];
   logic          r_press  [3];
   logic [CW-1:0] r_cnt    [3];

   assign w_key_raw = {key_commit_n, key_next_n, key_inc_n};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_key
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_sync1[gi]  <= 1'b1;
               r_sync2[gi]  <= 1'b1;
               r_stable[gi] <= 1'b1;
               r_press[gi]  <= 1'b0;
               r_cnt[gi]    <= '0;
            end else begin
               r_sync1[gi] <= w_key_raw[gi];
               r_sync2[gi] <= r_sync1[gi];
               r_press[gi] <= 1'b0;
               if (r_sync2[gi] != r_stable[gi]) begin
                  if (r_cnt[gi] == L_DEB_LAST) begin
                     r_stable[gi] <= r_sync2[gi];
                     r_cnt[gi]    <= '0;
                     // only the falling (press) edge is an event
                     r_press[gi]  <= ~r_sync2[gi];
                  end else begin
                     r_cnt[gi] <= r_cnt[gi] + 1'b1;
                  end
               end else begin
                  r_cnt[gi] <= '0;
               end
            end
         end
         assign w_press[gi] = r_press[gi];
      end
   endgenerate

   assign w_edit_digit = r_buf[{r_cursor, 2'b00} +: 4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_EDIT;
         r_buf       <= INIT_MEM;
         r_mem       <= INIT_MEM;
         r_cursor    <= 4'd0;
         r_mem_valid <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_buf       <= w_buf_next;
         r_mem       <= w_mem_next;
         r_cursor    <= w_cursor_next;
         r_mem_valid <= w_mem_valid_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_buf_next       = r_buf;
      w_mem_next       = r_mem;
      w_cursor_next    = r_cursor;
      w_mem_valid_next = 1'b0;
      case (r_state)
         S_EDIT: begin
            if (w_press[2]) begin
               w_mem_next       = r_buf;
               w_mem_valid_next = 1'b1;
               w_state_next     = S_COMMIT;
            end else if (w_press[1]) begin
               w_cursor_next = (r_cursor == 4'd9) ? 4'd0 : r_cursor + 4'd1;
            end else if (w_press[0]) begin
               w_buf_next[{r_cursor, 2'b00} +: 4] =
                  (w_edit_digit == L_DIGIT_MAX) ? 4'd0 : w_edit_digit + 4'd1;
            end
         end
         S_COMMIT: begin
            // presses landing in this cycle are intentionally dropped
            w_state_next = S_EDIT;
         end
         default: w_state_next = S_EDIT;
      endcase
   end

   // Free-running blink divider, independent of key activity
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b0;
      end else if (r_blink_cnt == L_BLINK_LAST) begin
         r_blink_cnt <= '0;
         r_blink     <= ~r_blink;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   assign mem        = r_mem;
   assign mem_valid  = r_mem_valid;
   assign cursor     = r_cursor;
   assign edit_digit = w_edit_digit;
   assign blink      = r_blink;
   assign dirty      = (r_buf != r_mem);

endmodule

// File: tb/tb_digit_entry_writer.sv
// Randomized key-sequence bench for digit_entry_writer, checked against a digit-array model.
module tb_digit_entry_writer;

   localparam int DEB = 4;
   localparam int BLK = 8;
   localparam logic [39:0] INIT = 40'h0987654321;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_inc_n = 1'b1;
   logic        key_next_n = 1'b1;
   logic        key_commit_n = 1'b1;
   logic [39:0] mem;
   logic        mem_valid;
   logic [3:0]  cursor;
   logic [3:0]  edit_digit;
   logic        blink;
   logic        dirty;

   always #5 clk = ~clk;

   digit_entry_writer #(
      .DEBOUNCE_CNT (DEB),
      .BLINK_CNT    (BLK),
      .DIGIT_MAX    (15),
      .INIT_MEM     (INIT)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_inc_n    (key_inc_n),
      .key_next_n   (key_next_n),
      .key_commit_n (key_commit_n),
      .mem          (mem),
      .mem_valid    (mem_valid),
      .cursor       (cursor),
      .edit_digit   (edit_digit),
      .blink        (blink),
      .dirty        (dirty)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: plain digit arrays
   int m_buf [10];
   int m_mem [10];
   int m_cur;
   int m_commits;

   function automatic logic [39:0] buf_word();
      logic [39:0] w;
      w = '0;
      for (int i = 0; i < 10; i++) w[4*i +: 4] = 4'(m_buf[i]);
      return w;
   endfunction

   function automatic logic [39:0] mem_word();
      logic [39:0] w;
      w = '0;
      for (int i = 0; i < 10; i++) w[4*i +: 4] = 4'(m_mem[i]);
      return w;
   endfunction

   task automatic model_reset();
      logic [39:0] iv;
      iv = INIT;
      for (int i = 0; i < 10; i++) begin
         m_buf[i] = int'(iv[4*i +: 4]);
         m_mem[i] = m_buf[i];
      end
      m_cur = 0;
   endtask

   task automatic model_inc();
      m_buf[m_cur] = (m_buf[m_cur] + 1) % 16;
   endtask

   task automatic model_next();
      m_cur = (m_cur + 1) % 10;
   endtask

   task automatic model_commit();
      for (int i = 0; i < 10; i++) m_mem[i] = m_buf[i];
      m_commits++;
   endtask

   // Monitors: blink period from cycle count, mem_valid pulse count and width
   int   n_cyc = 0;
   int   n_valid = 0;
   logic prev_valid = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) n_cyc <= 0;
      else        n_cyc <= n_cyc + 1;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check_val("blink", 40'(blink), 40'((n_cyc / BLK) % 2));
         if (mem_valid) begin
            n_valid++;
            check_val("valid_width", 40'(prev_valid), 40'd0);
         end
         prev_valid = mem_valid;
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic check_state(input string tag);
      check_val({tag, "_mem"},    mem, mem_word());
      check_val({tag, "_cursor"}, 40'(cursor), 40'(m_cur));
      check_val({tag, "_edit"},   40'(edit_digit), 40'(m_buf[m_cur]));
      check_val({tag, "_dirty"},  40'(dirty), 40'(buf_word() != mem_word()));
      check_val({tag, "_valids"}, 40'(n_valid), 40'(m_commits));
      $display("txn %s: mem=%h cursor=%0d edit=%0d dirty=%0b", tag, mem, cursor, edit_digit, dirty);
   endtask

   // m0 keys held for 'hold' cycles; m1 keys held for the same length one cycle later
   task automatic drive(input logic [2:0] m0, input logic [2:0] m1, input int hold, input int gap);
      logic [2:0] a;
      for (int k = 0; k <= hold; k++) begin
         @(negedge clk);
         a = ((k < hold) ? m0 : 3'b000) | ((k >= 1) ? m1 : 3'b000);
         key_inc_n    = ~a[0];
         key_next_n   = ~a[1];
         key_commit_n = ~a[2];
      end
      key_inc_n    = 1'b1;
      key_next_n   = 1'b1;
      key_commit_n = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   initial begin
      int op, hold, presses;
      bit seen;
      model_reset();
      m_commits = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_state("reset");
      check_val("reset_edit_const", 40'(edit_digit), 40'd1);
      repeat (20) @(negedge clk);
      check_state("idle");

      // exact press latency: old value after 6 edges, new after 7
      key_inc_n = 1'b0;
      repeat (6) @(negedge clk);
      check_val("lat_before", 40'(edit_digit), 40'd1);
      @(negedge clk);
      check_val("lat_after", 40'(edit_digit), 40'd2);
      repeat (3) @(negedge clk);
      key_inc_n = 1'b1;
      repeat (14) @(negedge clk);
      model_inc();
      check_state("hold10");

      drive(3'b001, 3'b000, 2, 14);
      check_state("glitch");

      for (int i = 0; i < 16; i++) begin
         drive(3'b001, 3'b000, 5, 14);
         model_inc();
         check_val("inc_seq", 40'(edit_digit), 40'(m_buf[m_cur]));
      end
      for (int i = 0; i < 10; i++) begin
         drive(3'b010, 3'b000, 5, 14);
         model_next();
         check_val("next_seq", 40'(cursor), 40'(m_cur));
      end

      presses = (5 - m_buf[0] + 16) % 16;
      for (int i = 0; i < presses; i++) begin
         drive(3'b001, 3'b000, 4, 14);
         model_inc();
      end
      drive(3'b100, 3'b000, 5, 14);
      model_commit();
      check_state("commit");
      check_val("commit_const", mem, 40'h0987654325);

      drive(3'b101, 3'b000, 6, 14);
      model_commit();
      check_state("commit_inc_same");

      for (int t = 0; t < 60; t++) begin
         op   = $urandom_range(0, 6);
         hold = (op == 6) ? $urandom_range(1, DEB - 1) : $urandom_range(DEB, 10);
         case (op)
            0: begin drive(3'b001, 3'b000, hold, 14); model_inc();    end
            1: begin drive(3'b010, 3'b000, hold, 14); model_next();   end
            2: begin drive(3'b100, 3'b000, hold, 14); model_commit(); end
            3: begin drive(3'b101, 3'b000, hold, 14); model_commit(); end
            4: begin drive(3'b011, 3'b000, hold, 14); model_next();   end
            5: begin drive(3'b100, 3'b001, hold, 14); model_commit(); end
            default: drive(3'(1 << $urandom_range(0, 2)), 3'b000, hold, 14);
         endcase
         check_state($sformatf("rand%0d_op%0d", t, op));
      end

      // reset asserted while the commit pulse is high
      if (buf_word() == INIT) begin
         drive(3'b001, 3'b000, 5, 14);
         model_inc();
      end
      @(negedge clk);
      key_commit_n = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         if (mem_valid) seen = 1'b1;
      end
      check_val("commit_seen", 40'(seen), 40'd1);
      check_val("commit_pub", mem, buf_word());
      rst_n = 1'b0;
      #1;
      check_val("rst_valid", 40'(mem_valid), 40'd0);
      check_val("rst_mem", mem, INIT);
      check_val("rst_cursor", 40'(cursor), 40'd0);
      check_val("rst_dirty", 40'(dirty), 40'd0);
      key_commit_n = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check_val("post_rst_mem", mem, mem_word());
      check_val("post_rst_edit", 40'(edit_digit), 40'(m_buf[m_cur]));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
